spi_fsm: RTL and testbench
==========================

Name: spi_fsm

Overview:
- Transaction controller for the SPI slave datapath. Sits directly downstream of the shift register and consumes its parallel output.
- Decodes each transaction: one address/RW byte, then one data byte.
- Drives the shift register's parallel-load control, the data-memory write enable, the address latch and the MISO output-buffer enable.
- Clocked by the FPGA clock. Sees SCLK/CS only as conditioned, clk-synchronous signals.

Parameters:
- width, 8, shift-register/data width in bits. Address is width-1 bits; the RW flag is bit 0 of the first byte.
- cntw, 3, bit-counter width. Must satisfy 2^cntw >= width.

Ports:
- clk  input  1  FPGA clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- cs_n  input  1  conditioned chip select, active low, clk-synchronous.
- sclk_rise  input  1  one-clk pulse per conditioned SCLK rising edge.
- sclk_fall  input  1  one-clk pulse per conditioned SCLK falling edge.
- sr_pout  input  width  shift-register parallel contents. Reflects a shift one clk after sclk_rise.
- sr_load  output  1  shift-register parallelLoad (load from memory).
- dm_we  output  1  data-memory write enable; one-clk pulse.
- addr_we  output  1  address-latch strobe; one-clk pulse.
- addr  output  width-1  latched address.
- rw  output  1  latched RW flag; 1 = read.
- miso_oe  output  1  MISO tristate-buffer enable.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, counter 0, addr 0, rw 0. All outputs low.
- Outputs sr_load, dm_we, addr_we, miso_oe and busy are Moore-decoded from the registered state. No combinational path from inputs to outputs.
- States and transitions:
  - IDLE: counter cleared. cs_n low → GET_ADDR next clk.
  - GET_ADDR: each sclk_rise increments the counter. The sclk_rise that arrives with counter == width-1 → DECODE, counter cleared.
  - DECODE (1 clk): addr <= sr_pout[width-1:1], rw <= sr_pout[0]. addr_we = 1. Next state: READ_LOAD if sr_pout[0] = 1, else WRITE_GET.
  - READ_LOAD (1 clk): sr_load = 1. Memory read is combinational, so the shift register captures mem[addr] this clk. Next state READ_SHIFT.
  - READ_SHIFT: miso_oe = 1. Each sclk_fall increments the counter. The sclk_fall with counter == width-1 → DONE.
  - WRITE_GET: counts sclk_rise as in GET_ADDR. The width-th sclk_rise → WRITE_COMMIT.
  - WRITE_COMMIT (1 clk): dm_we = 1. Memory writes sr_pout to addr. Next state DONE.
  - DONE: all enables low, busy = 1. Waits for cs_n high.
- Any state: cs_n high → IDLE next clk. This takes priority over all other transitions.
  - Abort before WRITE_COMMIT: dm_we never asserts and memory is unchanged.
  - Abort in READ_SHIFT: miso_oe drops the next clk.
- sclk_rise/sclk_fall pulses arriving in IDLE, DECODE, READ_LOAD, WRITE_COMMIT or DONE are ignored. Counter is unchanged.
- sclk_fall is ignored in GET_ADDR and WRITE_GET. sclk_rise is ignored in READ_SHIFT.
- sclk_rise and sclk_fall high in the same clk: only the edge relevant to the current state counts.
- Counter reaching width-1 never wraps silently: the terminal edge always causes the state exit.
- addr and rw hold their value until the next DECODE. They are not cleared by cs_n rising.
- Upstream requirement: the first sclk_rise arrives at least 2 clks after cs_n falls. An edge arriving during the IDLE→GET_ADDR clk is dropped.
- Latency: addr_we asserts 1 clk after the 8th address sclk_rise.
  - Write: dm_we asserts 1 clk after the 8th data sclk_rise.
  - Read: sr_load asserts 2 clks after the 8th address sclk_rise.

Test Plan:
- Reset mid-transaction: assert rst_n low while in READ_SHIFT → all outputs 0 immediately (async), addr = 0, state IDLE after release.
- Write: cs_n low, shift 0x54 (addr 0x2A, rw = 0), then 0xC3 → addr_we pulse, addr = 0x2A, rw = 0. Then exactly one dm_we pulse with sr_pout = 0xC3, busy until cs_n high.
- Read: cs_n low, shift 0x55 (addr 0x2A, rw = 1) → addr_we pulse, then sr_load high for exactly 1 clk 2 clks after the 8th rise. miso_oe high for exactly 8 sclk_fall pulses, then low in DONE.
- Abort: write transaction with cs_n raised after 5 data bits → dm_we never asserts, state IDLE 1 clk later.
- Back-to-back: two writes separated by 1 clk of cs_n high → both commit. addr latches each address in turn.
- Ignored edges: inject sclk_rise during DECODE and WRITE_COMMIT → counter unchanged, dm_we still fires after exactly 8 WRITE_GET rises.

Source files
------------

// File: rtl/spi_fsm.sv
// Transaction controller for the SPI slave datapath: decodes one address/RW byte
// then one data byte, and drives the shift-register load, memory write, address latch and MISO enable.
module spi_fsm #(
  parameter int width = 8,
  parameter int cntw  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs_n,
  input  logic             sclk_rise,
  input  logic             sclk_fall,
  input  logic [width-1:0] sr_pout,
  output logic             sr_load,
  output logic             dm_we,
  output logic             addr_we,
  output logic [width-2:0] addr,
  output logic             rw,
  output logic             miso_oe,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    DECODE,
    READ_LOAD,
    READ_SHIFT,
    WRITE_GET,
    WRITE_COMMIT,
    DONE
  } state_t;

  localparam logic [cntw-1:0] lastBit = cntw'(width - 1);

  state_t          state;
  state_t          nextState;
  logic [cntw-1:0] bitCount;
  logic [cntw-1:0] nextCount;

  // Next-state and bit-counter logic; a high chip select overrides every other transition.
  always_comb begin
    nextState = state;
    nextCount = bitCount;
    if (cs_n) begin
      nextState = IDLE;
      nextCount = '0;
    end else begin
      case (state)
        IDLE: begin
          nextCount = '0;
          nextState = GET_ADDR;
        end
        GET_ADDR, WRITE_GET: begin
          if (sclk_rise) begin
            if (bitCount == lastBit) begin
              nextCount = '0;
              nextState = (state == GET_ADDR) ? DECODE : WRITE_COMMIT;
            end else begin
              nextCount = bitCount + 1'b1;
            end
          end
        end
        DECODE:       nextState = sr_pout[0] ? READ_LOAD : WRITE_GET;
        READ_LOAD:    nextState = READ_SHIFT;
        READ_SHIFT: begin
          if (sclk_fall) begin
            if (bitCount == lastBit) begin
              nextCount = '0;
              nextState = DONE;
            end else begin
              nextCount = bitCount + 1'b1;
            end
          end
        end
        WRITE_COMMIT: nextState = DONE;
        DONE:         nextState = DONE;
        default: begin
          nextState = IDLE;
          nextCount = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they equal a Moore decode of the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bitCount <= '0;
      addr     <= '0;
      rw       <= 1'b0;
      sr_load  <= 1'b0;
      dm_we    <= 1'b0;
      addr_we  <= 1'b0;
      miso_oe  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= nextState;
      bitCount <= nextCount;
      if (state == DECODE) begin
        addr <= sr_pout[width-1:1];
        rw   <= sr_pout[0];
      end
      sr_load <= (nextState == READ_LOAD);
      dm_we   <= (nextState == WRITE_COMMIT);
      addr_we <= (nextState == DECODE);
      miso_oe <= (nextState == READ_SHIFT);
      busy    <= (nextState != IDLE);
    end
  end

endmodule

// File: tb/tb_spi_fsm.sv
// Directed bench for spi_fsm with a shift-register model and a scoreboard of
// expected address latches and memory commits.
module tb_spi_fsm;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b1;
  logic       cs_n      = 1'b1;
  logic       sclk_rise = 1'b0;
  logic       sclk_fall = 1'b0;
  logic       mosi      = 1'b0;
  logic [7:0] sr_pout   = 8'h00;
  logic       sr_load;
  logic       dm_we;
  logic       addr_we;
  logic [6:0] addr;
  logic       rw;
  logic       miso_oe;
  logic       busy;

  int total     = 0;
  int bad       = 0;
  int dmWeCount = 0;
  int savedCount;
  logic addrWePrev = 1'b0;
  logic [7:0] mem [128];

  typedef struct {logic [6:0] addr; logic rw;} addrExp_t;
  typedef struct {logic [6:0] addr; logic [7:0] data;} dataExp_t;
  addrExp_t addrQ[$];
  dataExp_t dataQ[$];
  addrExp_t monAddr;
  dataExp_t monData;

  spi_fsm #(.width(8), .cntw(3)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sclk_rise(sclk_rise), .sclk_fall(sclk_fall),
    .sr_pout(sr_pout), .sr_load(sr_load), .dm_we(dm_we), .addr_we(addr_we),
    .addr(addr), .rw(rw), .miso_oe(miso_oe), .busy(busy)
  );

  always #5 clk = ~clk;

  // Shift register and memory around the controller
  always @(posedge clk) begin
    if (sr_load) sr_pout <= mem[addr];
    else if (sclk_rise) sr_pout <= {sr_pout[6:0], mosi};
    if (dm_we) mem[addr] <= sr_pout;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic idleClk(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic rise, input logic fall, input logic bitIn);
    sclk_rise = rise;
    sclk_fall = fall;
    mosi      = bitIn;
    @(posedge clk);
    #1;
    sclk_rise = 1'b0;
    sclk_fall = 1'b0;
  endtask

  task automatic shiftBits(input logic [7:0] b, input int first, input int last);
    for (int i = first; i >= last; i--) begin
      applyStimulus(1'b1, 1'b0, b[i]);
      if (i != last) idleClk();
    end
  endtask

  task automatic startTxn();
    cs_n = 1'b0;
    idleClk(2);
  endtask

  // Scoreboard: the address is checked the clk after the addr_we pulse, data during dm_we
  always @(negedge clk) begin
    if (!rst_n) begin
      addrWePrev = 1'b0;
    end else begin
      if (addrWePrev) begin
        checkOutput("addrQueueNonEmpty", 32'(addrQ.size() != 0), 1);
        if (addrQ.size() != 0) begin
          monAddr = addrQ.pop_front();
          checkOutput("addrLatch", addr, monAddr.addr);
          checkOutput("rwLatch", rw, monAddr.rw);
        end
      end
      if (dm_we) begin
        dmWeCount++;
        checkOutput("dataQueueNonEmpty", 32'(dataQ.size() != 0), 1);
        if (dataQ.size() != 0) begin
          monData = dataQ.pop_front();
          checkOutput("commitAddr", addr, monData.addr);
          checkOutput("commitData", sr_pout, monData.data);
        end
      end
      addrWePrev = addr_we;
    end
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'(i ^ 8'h5A);
    mem[7'h2A] = 8'h96;

    // Power-on reset
    #2 rst_n = 1'b0;
    idleClk(2);
    checkOutput("rstSrLoad", sr_load, 0);
    checkOutput("rstDmWe", dm_we, 0);
    checkOutput("rstAddrWe", addr_we, 0);
    checkOutput("rstMisoOe", miso_oe, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstAddr", addr, 0);
    checkOutput("rstRw", rw, 0);
    rst_n = 1'b1;
    idleClk(2);
    checkOutput("idleBusy", busy, 0);

    // Write 0xC3 to address 0x2A
    addrQ.push_back('{addr: 7'h2A, rw: 1'b0});
    dataQ.push_back('{addr: 7'h2A, data: 8'hC3});
    cs_n = 1'b0;
    idleClk();
    checkOutput("wrBusyStart", busy, 1);
    idleClk();
    shiftBits(8'h54, 7, 0);
    checkOutput("wrAddrWe", addr_we, 1);
    idleClk();
    checkOutput("wrAddrWeEnd", addr_we, 0);
    shiftBits(8'hC3, 7, 1);
    idleClk();
    checkOutput("wrNoEarlyDmWe", dm_we, 0);
    shiftBits(8'hC3, 0, 0);
    checkOutput("wrDmWe", dm_we, 1);
    idleClk();
    checkOutput("wrDmWePulse", dm_we, 0);
    checkOutput("wrBusyDone", busy, 1);
    idleClk();
    checkOutput("wrBusyHold", busy, 1);
    cs_n = 1'b1;
    idleClk();
    checkOutput("wrBusyEnd", busy, 0);
    checkOutput("wrCommitCount", dmWeCount, 1);

    // Read from address 0x2A
    addrQ.push_back('{addr: 7'h2A, rw: 1'b1});
    startTxn();
    shiftBits(8'h55, 7, 0);
    checkOutput("rdAddrWe", addr_we, 1);
    checkOutput("rdSrLoadEarly", sr_load, 0);
    idleClk();
    checkOutput("rdSrLoad", sr_load, 1);
    checkOutput("rdMisoOffLoad", miso_oe, 0);
    idleClk();
    checkOutput("rdSrLoadPulse", sr_load, 0);
    checkOutput("rdMisoOn", miso_oe, 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("rdRiseIgnored", miso_oe, 1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("rdMisoFall", miso_oe, 32'(i < 7));
      if (i < 7) idleClk();
    end
    checkOutput("rdBusyDone", busy, 1);
    cs_n = 1'b1;
    idleClk();
    checkOutput("rdBusyEnd", busy, 0);
    checkOutput("rdAddrHold", addr, 7'h2A);
    checkOutput("rdRwHold", rw, 1);
    checkOutput("rdNoCommit", dmWeCount, 1);

    // Write with stray edges during DECODE, WRITE_GET and WRITE_COMMIT
    addrQ.push_back('{addr: 7'h15, rw: 1'b0});
    dataQ.push_back('{addr: 7'h15, data: 8'h69});
    startTxn();
    shiftBits(8'h2A, 7, 0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    shiftBits(8'h69, 7, 1);
    idleClk();
    checkOutput("igNoEarlyDmWe", dm_we, 0);
    shiftBits(8'h69, 0, 0);
    checkOutput("igDmWe", dm_we, 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("igDmWePulse", dm_we, 0);
    checkOutput("igBusyDone", busy, 1);
    cs_n = 1'b1;
    idleClk();
    checkOutput("igCommitCount", dmWeCount, 2);

    // Abort a write after five data bits
    addrQ.push_back('{addr: 7'h10, rw: 1'b0});
    savedCount = dmWeCount;
    startTxn();
    shiftBits(8'h20, 7, 0);
    idleClk();
    shiftBits(8'hFF, 7, 3);
    idleClk();
    cs_n = 1'b1;
    idleClk();
    checkOutput("abBusy", busy, 0);
    idleClk(12);
    checkOutput("abNoCommit", dmWeCount, savedCount);
    checkOutput("abMemUnchanged", mem[7'h10], 8'h4A);

    // Back-to-back writes separated by one clk of cs_n high
    addrQ.push_back('{addr: 7'h11, rw: 1'b0});
    dataQ.push_back('{addr: 7'h11, data: 8'hA5});
    addrQ.push_back('{addr: 7'h3C, rw: 1'b0});
    dataQ.push_back('{addr: 7'h3C, data: 8'h5A});
    startTxn();
    shiftBits(8'h22, 7, 0);
    idleClk();
    checkOutput("b2bAddrA", addr, 7'h11);
    shiftBits(8'hA5, 7, 0);
    checkOutput("b2bDmWeA", dm_we, 1);
    idleClk();
    cs_n = 1'b1;
    idleClk();
    checkOutput("b2bIdleGap", busy, 0);
    cs_n = 1'b0;
    idleClk();
    checkOutput("b2bRestart", busy, 1);
    idleClk();
    shiftBits(8'h78, 7, 0);
    idleClk();
    checkOutput("b2bAddrB", addr, 7'h3C);
    shiftBits(8'h5A, 7, 0);
    checkOutput("b2bDmWeB", dm_we, 1);
    idleClk();
    cs_n = 1'b1;
    idleClk();
    checkOutput("b2bCommitCount", dmWeCount, savedCount + 2);
    checkOutput("b2bMemA", mem[7'h11], 8'hA5);
    checkOutput("b2bMemB", mem[7'h3C], 8'h5A);

    // Asynchronous reset in the middle of a read
    addrQ.push_back('{addr: 7'h2A, rw: 1'b1});
    startTxn();
    shiftBits(8'h55, 7, 0);
    idleClk(2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      idleClk();
    end
    checkOutput("rsMisoBefore", miso_oe, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rsMiso", miso_oe, 0);
    checkOutput("rsBusy", busy, 0);
    checkOutput("rsSrLoad", sr_load, 0);
    checkOutput("rsAddr", addr, 0);
    checkOutput("rsRw", rw, 0);
    cs_n = 1'b1;
    idleClk();
    rst_n = 1'b1;
    idleClk(2);
    checkOutput("rsIdle", busy, 0);
    checkOutput("rsAddrAfter", addr, 0);

    checkOutput("addrQueueDrained", addrQ.size(), 0);
    checkOutput("dataQueueDrained", dataQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
